// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

    localparam logic [31:0] FETCH_BUBBLE = 32'h0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones, cleared only by reset.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: one outstanding imem request, stale-response drop,
// and an instruction buffer that holds an arrival across a hazard stall.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] PCF,
    input  logic              HazardStallF,
    input  logic              BranchTakenE,
    input  logic              PCSrcW,
    output logic              ImemReq,
    output logic [ADDR_W-1:0] ImemAddr,
    input  logic              ImemReady,
    input  logic              ImemRValid,
    input  logic [31:0]       ImemRData,
    output logic [31:0]       InstrF,
    output logic              InstrValidF,
    output logic              StallF,
    output logic              FlushD,
    output logic [CNT_W-1:0]  FetchStallCnt
);

    fetch_state_e r_state;
    fetch_state_e w_nextState;
    logic [31:0]  r_instrBuf;
    logic         w_redirect;
    logic         w_capture;
    logic         w_deliver;

    assign w_redirect = BranchTakenE | PCSrcW;
    assign ImemAddr   = PCF;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= REQ;
            r_instrBuf <= FETCH_BUBBLE;
        end else begin
            r_state <= w_nextState;
            if (w_capture) begin
                r_instrBuf <= ImemRData;
            end
        end
    end

    // A redirect always wins: it suppresses new requests and turns any
    // response arriving in the same cycle into a discard.
    always_comb begin
        w_nextState = r_state;
        w_capture   = 1'b0;
        w_deliver   = 1'b0;
        ImemReq     = 1'b0;
        InstrValidF = 1'b0;
        InstrF      = FETCH_BUBBLE;
        case (r_state)
            REQ: begin
                ImemReq = ~w_redirect;
                if (!w_redirect && ImemReady) begin
                    w_nextState = WAIT;
                end
            end
            WAIT: begin
                if (ImemRValid) begin
                    if (w_redirect) begin
                        w_nextState = REQ;
                    end else if (HazardStallF) begin
                        w_capture   = 1'b1;
                        w_nextState = HOLD;
                    end else begin
                        w_deliver   = 1'b1;
                        InstrValidF = 1'b1;
                        InstrF      = ImemRData;
                        w_nextState = REQ;
                    end
                end else if (w_redirect) begin
                    w_nextState = DROP;
                end
            end
            DROP: begin
                if (ImemRValid) begin
                    w_nextState = REQ;
                end
            end
            HOLD: begin
                InstrValidF = 1'b1;
                InstrF      = r_instrBuf;
                if (w_redirect) begin
                    w_nextState = REQ;
                end else if (!HazardStallF) begin
                    w_deliver   = 1'b1;
                    w_nextState = REQ;
                end
            end
            default: begin
                w_nextState = REQ;
            end
        endcase
        if (reset) begin
            ImemReq     = 1'b0;
            InstrValidF = 1'b0;
            InstrF      = FETCH_BUBBLE;
        end
    end

    assign StallF = reset | ~(w_redirect | w_deliver);
    assign FlushD = w_redirect | ~InstrValidF;

    sat_counter #(.CNT_W(CNT_W)) u_stallCnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (StallF),
        .o_count (FetchStallCnt)
    );

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Sequences the fetch stage of the pipelined ARM core against a variable-latency instruction memory.
- Issues one instruction-memory request per fetch and holds the PC with `StallF` until the instruction arrives.
- Discards responses that become stale after a branch or PC-write redirect.
- Buffers an arrived instruction while the hazard unit stalls fetch.
- Sits between the fetch datapath (which owns the PC register) and the instruction-memory port, and feeds decode.

## Interface
- `ADDR_W`, 32, fetch address width
- `CNT_W`, 16, width of the stall-cycle counter
- `clk` in 1: core clock
- `reset` in 1: synchronous, active-high
- `PCF` in ADDR_W: current fetch PC from the fetch datapath
- `HazardStallF` in 1: hazard unit requests a fetch stall (load-use)
- `BranchTakenE` in 1: branch resolved taken in Execute
- `PCSrcW` in 1: PC written in Writeback
- `ImemReq` out 1: request valid
- `ImemAddr` out ADDR_W: request address
- `ImemReady` in 1: memory accepts request this cycle
- `ImemRValid` in 1: response valid
- `ImemRData` in 32: response instruction
- `InstrF` out 32: instruction to decode
- `InstrValidF` out 1: `InstrF` valid this cycle
- `StallF` out 1: hold PC register (PC loads when low)
- `FlushD` out 1: squash Decode register
- `FetchStallCnt` out CNT_W: saturating count of cycles with `StallF`=1

## Operation
- Redirect = `BranchTakenE | PCSrcW`.
- At most one request is outstanding. Responses arrive ≥1 cycle after acceptance, in order.
- States:
  - REQ: `ImemReq`=1, `ImemAddr`=`PCF`. Redirect → stays in REQ; the request is not issued (`ImemReq` forced 0). Else `ImemReady` → WAIT.
  - WAIT: `ImemRValid` with no redirect and no `HazardStallF` → deliver, go REQ. `ImemRValid` with `HazardStallF` → capture into `InstrBuf`, go HOLD. `ImemRValid` with redirect → discard, go REQ. Redirect without `ImemRValid` → go DROP.
  - DROP: wait for the stale response. `ImemRValid` → discard, go REQ. A further redirect stays in DROP.
  - HOLD: `InstrValidF`=1, `InstrF`=`InstrBuf`. `HazardStallF` falling → deliver, go REQ. Redirect → discard, go REQ.
- Deliver means: `InstrValidF`=1, `InstrF`=response data (or `InstrBuf` from HOLD), `StallF`=0.
- `StallF`:
  - 0 in any redirect cycle (PC must load the target), in every state.
  - 0 in deliver cycles.
  - 1 otherwise.
- Redirect overrides `HazardStallF`.
- `FlushD` = redirect | ~`InstrValidF`, so a bubble enters Decode whenever nothing valid is presented.
- `InstrF` = 0 whenever `InstrValidF`=0.
- `FetchStallCnt` increments each cycle `StallF`=1 and saturates at all-ones. Only `reset` clears it.

## Timing
- Reset: state → REQ on the next edge; `FetchStallCnt`=0, `InstrBuf`=0.
- Outputs during and immediately after reset:
  - While `reset`=1: `ImemReq`=0, `StallF`=1, `FlushD`=1, `InstrValidF`=0, `InstrF`=0.
  - First cycle after reset: `ImemReq`=1 with `ImemAddr`=`PCF`=0.
- Reset mid-operation: the memory shares `reset`, so nothing is outstanding afterwards. Any in-flight response is abandoned.
- Zero-wait memory (ready in REQ, rvalid next cycle) gives 2 cycles per instruction. Each extra memory wait cycle adds one.
- Outputs are combinational from state and inputs. State, `InstrBuf` and the counter are registered.
- Boundaries:
  - Redirect and `ImemRValid` in the same cycle: discard the data, no DROP.
  - Redirect in REQ with `ImemReady`=1: no request is issued.
  - Counter at max stays at max.

## Structure
- `fetch_pkg`: state enum (REQ, WAIT, DROP, HOLD) and a `FETCH_BUBBLE`=32'h0 constant.
- Sub-module: `sat_counter #(CNT_W)` for `FetchStallCnt`.
- FSM and `InstrBuf` stay inline.

## Test plan
- Reset, PCF=0, ready and rvalid on first opportunity with data 32'hE3A01005 → `ImemAddr`=0, delivery on cycle 2 with `StallF`=0, `FlushD`=0; steady state 2 cycles per instruction.
- 3 wait cycles before rvalid → `StallF`=1 for 4 cycles, `FetchStallCnt` +4, `FlushD`=1 each cycle.
- `BranchTakenE` in WAIT, rvalid 2 cycles later with 32'hDEADBEEF → `StallF`=0 in the redirect cycle, DROP; no `InstrValidF`, next `ImemReq` carries the new PCF.
- rvalid with `HazardStallF`=1 for 2 cycles → HOLD, `InstrValidF`=1, `StallF`=1; delivered with `StallF`=0 when the stall falls.
- `PCSrcW` and `ImemRValid` in the same cycle → data discarded, REQ next cycle, no DROP.
- Force `FetchStallCnt` to 16'hFFFE, stall 3 cycles → saturates at 16'hFFFF.
